// File: rtl/cla_arbiter.sv
// cla_arbiter: shares one CLA_32bit adder between two valid/ready requesters
// (port 0 = ALU add/sub, port 1 = PC/address incrementer) and returns the
// result through a one-entry output buffer with its own valid/ready handshake.
//
// Optional feature macro: CLA_ARB_RR_EN
//   defined   -> round-robin on a tie (grant the port that did not win last)
//   undefined -> fixed priority on a tie (port 0 always wins)
//
// Buffer FSM
//   state     | meaning
//   BUF_EMPTY | no result held, res_valid = 0
//   BUF_FULL  | result held until the consumer takes it, res_valid = 1

module CLA_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [31:0] g;
    logic [31:0] p;
    logic [3:0]  grp_g;
    logic [3:0]  grp_p;
    logic        carry;
    logic        c1;
    logic        c2;
    logic        c3;
    logic        blk_g;
    logic        blk_p;

    // 4-bit lookahead blocks chained through their block generate/propagate
    always_comb begin
        g     = a & b;
        p     = a ^ b;
        sum   = '0;
        carry = cin;
        grp_g = '0;
        grp_p = '0;
        c1    = 1'b0;
        c2    = 1'b0;
        c3    = 1'b0;
        blk_g = 1'b0;
        blk_p = 1'b0;
        for (int k = 0; k < 8; k++) begin
            grp_g = g[4*k +: 4];
            grp_p = p[4*k +: 4];
            c1 = grp_g[0] | (grp_p[0] & carry);
            c2 = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & carry);
            c3 = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
               | (grp_p[2] & grp_p[1] & grp_p[0] & carry);
            blk_g = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
                  | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0]);
            blk_p = &grp_p;
            sum[4*k +: 4] = grp_p ^ {c3, c2, c1, carry};
            carry = blk_g | (blk_p & carry);
        end
        cout = carry;
    end

endmodule

module cla_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             res_ovf,
    output logic             res_id
);

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

    buf_state_e       state_q, state_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             id_q, id_d;
    logic             last_grant_q, last_grant_d;

    logic             accept;
    logic             grant;
    logic             xfer;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

`ifndef CLA_ARB_RR_EN
    // last_grant is still tracked in fixed-priority builds, just not consulted
    logic unused_last_grant;
    assign unused_last_grant = last_grant_q;
`endif

    // Arbitration and request-side handshake; grant defaults to port 0 when idle
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef CLA_ARB_RR_EN
            grant = ~last_grant_q;
`else
            grant = 1'b0;
`endif
        end else if (req1_valid) begin
            grant = 1'b1;
        end
        accept     = (state_q == BUF_EMPTY) || res_ready;
        req0_ready = accept && !grant && !reset;
        req1_ready = accept && grant && !reset;
        xfer       = accept && (req0_valid || req1_valid) && !reset;
    end

    // Operand mux in front of the shared adder
    always_comb begin
        add_a   = grant ? req1_a   : req0_a;
        add_b   = grant ? req1_b   : req0_b;
        add_cin = grant ? req1_cin : req0_cin;
    end

    CLA_32bit u_cla (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Buffer next state: load on transfer (overrides a same-cycle drain), else drain
    always_comb begin
        state_d      = state_q;
        sum_d        = sum_q;
        cout_d       = cout_q;
        ovf_d        = ovf_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        if (xfer) begin
            state_d      = BUF_FULL;
            sum_d        = add_sum;
            cout_d       = add_cout;
            ovf_d        = (add_a[WIDTH-1] == add_b[WIDTH-1]) && (add_sum[WIDTH-1] != add_a[WIDTH-1]);
            id_d         = grant;
            last_grant_d = grant;
        end else if ((state_q == BUF_FULL) && res_ready) begin
            state_d = BUF_EMPTY;
        end
    end

    // State registers with synchronous reset; last_grant resets to 1 so port 0 wins the first tie
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= BUF_EMPTY;
            sum_q        <= '0;
            cout_q       <= 1'b0;
            ovf_q        <= 1'b0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            sum_q        <= sum_d;
            cout_q       <= cout_d;
            ovf_q        <= ovf_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign res_valid = (state_q == BUF_FULL);
    assign res_sum   = sum_q;
    assign res_cout  = cout_q;
    assign res_ovf   = ovf_q;
    assign res_id    = id_q;

endmodule

// File: tb/tb_cla_arbiter.sv
// Self-checking bench for cla_arbiter: directed test-plan cases plus a
// randomized run against a transaction-level reference model.
module tb_cla_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req0_cin;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_cin;
    logic [31:0] req1_a, req1_b;
    logic        res_valid, res_ready;
    logic [31:0] res_sum;
    logic        res_cout, res_ovf, res_id;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model of the output buffer
    logic        m_valid;
    logic [31:0] m_sum;
    logic        m_cout, m_ovf, m_id;
    int          m_last;

    cla_arbiter #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_cout(res_cout), .res_ovf(res_ovf), .res_id(res_id)
    );

    always #5 clock = ~clock;

    // {cout, ovf, sum} from plain integer arithmetic
    function automatic logic [33:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic cin);
        longint unsigned u;
        longint s;
        longint sa;
        longint sb;
        logic ovf;
        u  = longint'(a) + longint'(b) + longint'(cin);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        s  = sa + sb + longint'(cin);
        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        return {u[32], ovf, u[31:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 5))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    // tie policy: winner is whichever port did not win last (RR) or port 0 (fixed)
    function automatic int model_grant(input logic v0, input logic v1);
        if (v0 && v1) begin
`ifdef CLA_ARB_RR_EN
            return (m_last == 0) ? 1 : 0;
`else
            return 0;
`endif
        end
        return (v1 && !v0) ? 1 : 0;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        req0_valid = 0; req0_a = '0; req0_b = '0; req0_cin = 0;
        req1_valid = 0; req1_a = '0; req1_b = '0; req1_cin = 0;
    endtask

    task automatic do_reset();
        reset = 1; idle();
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; res_ready = 0; idle();
        req0_valid = 1; req1_valid = 1;
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b00)
            $display("FAIL reset_ready got %b want 00", {req0_ready, req1_ready});
        else n_pass++;
        tick();
        reset = 0; idle();
        #1;
        n_checks++;
        if ({res_valid, res_sum, res_cout, res_ovf, res_id} !== 36'h0)
            $display("FAIL reset_outputs got %h want 0", {res_valid, res_sum, res_cout, res_ovf, res_id});
        else n_pass++;
    endtask

    task automatic test_single_adds();
        res_ready = 1;
        req0_valid = 1; req0_a = 32'hFFFF_FFFF; req0_b = 32'h0000_0001; req0_cin = 0;
        #1;
        n_checks++;
        if (req0_ready !== 1'b1) $display("FAIL p0_ready got %b want 1", req0_ready);
        else n_pass++;
        tick();
        idle();
        #1;
        n_checks++;
        if ({res_valid, res_sum, res_cout, res_ovf, res_id} !== {1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0})
            $display("FAIL p0_add got %h want %h", {res_valid, res_sum, res_cout, res_ovf, res_id},
                     {1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0});
        else n_pass++;

        req1_valid = 1; req1_a = 32'h1234_5678; req1_b = 32'h8765_4321; req1_cin = 1;
        #1;
        n_checks++;
        if (req1_ready !== 1'b1) $display("FAIL p1_ready got %b want 1", req1_ready);
        else n_pass++;
        tick();
        idle();
        #1;
        n_checks++;
        if ({res_valid, res_sum, res_cout, res_ovf, res_id} !== {1'b1, 32'h9999_999A, 1'b0, 1'b0, 1'b1})
            $display("FAIL p1_add got %h want %h", {res_valid, res_sum, res_cout, res_ovf, res_id},
                     {1'b1, 32'h9999_999A, 1'b0, 1'b0, 1'b1});
        else n_pass++;

        // drain with no request: buffer empties, data holds
        tick();
        n_checks++;
        if ({res_valid, res_sum, res_cout, res_ovf, res_id} !== {1'b0, 32'h9999_999A, 1'b0, 1'b0, 1'b1})
            $display("FAIL drain_hold got %h want %h", {res_valid, res_sum, res_cout, res_ovf, res_id},
                     {1'b0, 32'h9999_999A, 1'b0, 1'b0, 1'b1});
        else n_pass++;
    endtask

    task automatic test_backpressure();
        res_ready = 1;
        req0_valid = 1; req0_a = 32'h7FFF_FFFF; req0_b = 32'h0000_0001; req0_cin = 0;
        tick();
        idle();
        #1;
        n_checks++;
        if ({res_valid, res_sum, res_cout, res_ovf, res_id} !== {1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0})
            $display("FAIL ovf_pos got %h want %h", {res_valid, res_sum, res_cout, res_ovf, res_id},
                     {1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0});
        else n_pass++;

        res_ready = 0;
        req0_valid = 1; req0_a = 32'h8000_0000; req0_b = 32'h8000_0000; req0_cin = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if ({req0_ready, req1_ready} !== 2'b00)
                $display("FAIL bp_ready[%0d] got %b want 00", i, {req0_ready, req1_ready});
            else n_pass++;
            tick();
            n_checks++;
            if ({res_valid, res_sum, res_cout, res_ovf, res_id} !== {1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0})
                $display("FAIL bp_hold[%0d] got %h want %h", i, {res_valid, res_sum, res_cout, res_ovf, res_id},
                         {1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0});
            else n_pass++;
        end

        res_ready = 1;
        #1;
        n_checks++;
        if (req0_ready !== 1'b1) $display("FAIL bp_release_ready got %b want 1", req0_ready);
        else n_pass++;
        tick();
        idle();
        #1;
        n_checks++;
        if ({res_valid, res_sum, res_cout, res_ovf, res_id} !== {1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b0})
            $display("FAIL ovf_neg got %h want %h", {res_valid, res_sum, res_cout, res_ovf, res_id},
                     {1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b0});
        else n_pass++;
        tick();
    endtask

    task automatic test_tie();
        logic [33:0] r;
        logic [3:0]  exp_id;
`ifdef CLA_ARB_RR_EN
        exp_id = 4'b1010; // bit i = expected id of result i: 0,1,0,1
`else
        exp_id = 4'b0000;
`endif
        do_reset();
        res_ready = 1;
        req0_valid = 1; req0_a = rand_op(); req0_b = rand_op(); req0_cin = 1'($urandom_range(0, 1));
        req1_valid = 1; req1_a = rand_op(); req1_b = rand_op(); req1_cin = 1'($urandom_range(0, 1));
        for (int i = 0; i < 4; i++) begin
            #1;
`ifndef CLA_ARB_RR_EN
            n_checks++;
            if (req1_ready !== 1'b0) $display("FAIL tie_p1_ready[%0d] got %b want 0", i, req1_ready);
            else n_pass++;
`endif
            r = exp_id[i] ? ref_add(req1_a, req1_b, req1_cin) : ref_add(req0_a, req0_b, req0_cin);
            tick();
            n_checks++;
            if ({res_valid, res_sum, res_cout, res_ovf, res_id} !== {1'b1, r[31:0], r[33], r[32], exp_id[i]})
                $display("FAIL tie[%0d] got %h want %h", i, {res_valid, res_sum, res_cout, res_ovf, res_id},
                         {1'b1, r[31:0], r[33], r[32], exp_id[i]});
            else n_pass++;
            if (exp_id[i]) begin
                req1_a = rand_op(); req1_b = rand_op(); req1_cin = 1'($urandom_range(0, 1));
            end else begin
                req0_a = rand_op(); req0_b = rand_op(); req0_cin = 1'($urandom_range(0, 1));
            end
        end
        idle();
        tick();
    endtask

    task automatic test_reset_mid();
        res_ready = 0;
        req1_valid = 1; req1_a = $urandom; req1_b = $urandom; req1_cin = 1;
        tick();
        idle();
        #1;
        n_checks++;
        if (res_valid !== 1'b1) $display("FAIL mid_full got %b want 1", res_valid);
        else n_pass++;
        reset = 1;
        res_ready = 1;
        req0_valid = 1; req0_a = 32'h1; req0_b = 32'h2;
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b00)
            $display("FAIL mid_reset_ready got %b want 00", {req0_ready, req1_ready});
        else n_pass++;
        tick();
        reset = 0; idle();
        #1;
        n_checks++;
        if ({res_valid, res_sum, res_cout, res_ovf, res_id} !== 36'h0)
            $display("FAIL mid_reset_outputs got %h want 0", {res_valid, res_sum, res_cout, res_ovf, res_id});
        else n_pass++;
    endtask

    task automatic test_random();
        int          g;
        logic        x;
        logic        full;
        logic [33:0] r;
        do_reset();
        m_valid = 0; m_sum = '0; m_cout = 0; m_ovf = 0; m_id = 0; m_last = 1;
        idle();
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!req0_valid && ($urandom_range(0, 2) != 0)) begin
                req0_valid = 1; req0_a = rand_op(); req0_b = rand_op(); req0_cin = 1'($urandom_range(0, 1));
            end
            if (!req1_valid && ($urandom_range(0, 2) != 0)) begin
                req1_valid = 1; req1_a = rand_op(); req1_b = rand_op(); req1_cin = 1'($urandom_range(0, 1));
            end
            res_ready = ($urandom_range(0, 3) != 0);
            #1;
            full = m_valid;
            g = model_grant(req0_valid, req1_valid);
            x = (!full || res_ready) && (req0_valid || req1_valid);
            if (req0_valid) begin
                n_checks++;
                if (req0_ready !== (x && g == 0))
                    $display("FAIL rnd_ready0[%0d] got %b want %b", cyc, req0_ready, (x && g == 0));
                else n_pass++;
            end
            if (req1_valid) begin
                n_checks++;
                if (req1_ready !== (x && g == 1))
                    $display("FAIL rnd_ready1[%0d] got %b want %b", cyc, req1_ready, (x && g == 1));
                else n_pass++;
            end
            r = (g == 1) ? ref_add(req1_a, req1_b, req1_cin) : ref_add(req0_a, req0_b, req0_cin);
            tick();
            if (x) begin
                m_valid = 1; m_sum = r[31:0]; m_cout = r[33]; m_ovf = r[32]; m_id = 1'(g); m_last = g;
                if (g == 1) req1_valid = 0; else req0_valid = 0;
            end else if (full && res_ready) begin
                m_valid = 0;
            end
            n_checks++;
            if ({res_valid, res_sum, res_cout, res_ovf, res_id} !== {m_valid, m_sum, m_cout, m_ovf, m_id})
                $display("FAIL rnd_result[%0d] got %h want %h", cyc, {res_valid, res_sum, res_cout, res_ovf, res_id},
                         {m_valid, m_sum, m_cout, m_ovf, m_id});
            else n_pass++;
        end
        idle();
    endtask

    initial begin
        reset = 1; res_ready = 0; idle();
        tick();
        test_reset();
        test_single_adds();
        test_backpressure();
        test_tie();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
